// File: rtl/spi_flash_responder.sv
// SPI/QSPI read-only flash emulator; sclk/cs_n/dq oversampled in clk, memory read is 1-clk latency.
// Outputs follow the synchronised sclk by about 3 clk; no backpressure, image memory must answer every mem_rd.
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS     = 8'h00,
    parameter int          DUMMY_CLKS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic [3:0]            qdi,
    output logic [3:0]            qdo,
    output logic [3:0]            oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_data,
    output logic                  busy
);
    typedef enum logic [3:0] {IDLE, CMD, ADDR, DUMMY, DATA1, DATA4, ID, STAT, IGNORE} state_t;

    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_WIDTH - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLKS - 1);

    state_t                state, state_nxt;
    logic [1:0]            sclk_sy, cs_sy;
    logic [3:0]            qdi_m, qdi_s;
    logic                  sclk_d, sclk_s, cs_s, rise, fall;
    logic                  armed, drv, rd_pend, out_state, last_rise;
    logic [7:0]            cnt, cmd, mbuf, out_sr, src;
    logic [2:0]            ocnt, olast;
    logic [1:0]            id_idx;
    logic [ADDR_WIDTH-1:0] sh, sh_nxt;
    logic                  unused_qdi;

    assign sclk_s     = sclk_sy[1];
    assign cs_s       = cs_sy[1];
    assign rise       = sclk_s & ~sclk_d;
    assign fall       = ~sclk_s & sclk_d;
    assign sh_nxt     = {sh[ADDR_WIDTH-2:0], qdi_s[0]};
    assign unused_qdi = ^qdi_s[3:1];
    assign out_state  = (state == DATA1) || (state == DATA4) || (state == ID) || (state == STAT);
    assign olast      = (state == DATA4) ? 3'd1 : 3'd7;
    assign busy       = (state != IDLE);

    // cs_n synchroniser resets to "low" so a select already active at reset release is not mistaken for a new one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sy <= 2'b00;
            cs_sy   <= 2'b00;
            qdi_m   <= 4'h0;
            qdi_s   <= 4'h0;
            sclk_d  <= 1'b0;
        end else begin
            sclk_sy <= {sclk_sy[0], sclk};
            cs_sy   <= {cs_sy[0], cs_n};
            qdi_m   <= qdi;
            qdi_s   <= qdi_m;
            sclk_d  <= sclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last_rise = 1'b0;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (armed) state_nxt = CMD;
                CMD: if (rise && cnt == 8'd7) begin
                    last_rise = 1'b1;
                    case (sh_nxt[7:0])
                        8'h03, 8'h0B, 8'h6B: state_nxt = ADDR;
                        8'h9F:               state_nxt = ID;
                        8'h05:               state_nxt = STAT;
                        default:             state_nxt = IGNORE;
                    endcase
                end
                ADDR: if (rise && cnt == ADDR_LAST) begin
                    last_rise = 1'b1;
                    state_nxt = (cmd == 8'h03) ? DATA1 : DUMMY;
                end
                DUMMY: if (rise && cnt == DUMMY_LAST) begin
                    last_rise = 1'b1;
                    state_nxt = (cmd == 8'h6B) ? DATA4 : DATA1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        src = 8'h00;
        case (state)
            DATA1, DATA4: src = mbuf;
            STAT:         src = STATUS;
            ID: case (id_idx)
                2'd0:    src = JEDEC_ID[23:16];
                2'd1:    src = JEDEC_ID[15:8];
                2'd2:    src = JEDEC_ID[7:0];
                default: src = 8'hFF;
            endcase
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            cnt      <= 8'h00;
            sh       <= '0;
            cmd      <= 8'h00;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            rd_pend  <= 1'b0;
            mbuf     <= 8'h00;
            out_sr   <= 8'h00;
            ocnt     <= 3'd0;
            drv      <= 1'b0;
            id_idx   <= 2'd0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend) mbuf <= mem_data;
            if (cs_s) armed <= 1'b1;
            if (state_nxt != state) cnt <= 8'h00;
            else if (rise)          cnt <= cnt + 8'd1;
            if (rise) sh <= sh_nxt;
            if (last_rise && state == CMD) cmd <= sh_nxt[7:0];
            if (last_rise && state == ADDR) begin
                mem_addr <= sh_nxt;
                mem_rd   <= (cmd == 8'h03);
            end
            // dummy-cycle commands fetch their first byte as the dummy phase ends
            if (last_rise && state == DUMMY) mem_rd <= 1'b1;
            if (cs_s) begin
                drv    <= 1'b0;
                ocnt   <= 3'd0;
                id_idx <= 2'd0;
            end else if (fall && out_state) begin
                drv  <= 1'b1;
                ocnt <= (ocnt == olast) ? 3'd0 : ocnt + 3'd1;
                if (ocnt == 3'd0) begin
                    out_sr <= src;
                    if (state == DATA1 || state == DATA4) begin
                        mem_addr <= mem_addr + 1'b1;
                        mem_rd   <= 1'b1;
                    end
                    if (state == ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                end else begin
                    out_sr <= (state == DATA4) ? {out_sr[3:0], 4'h0} : {out_sr[6:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        qdo = 4'h0;
        oe  = 4'h0;
        if (drv) begin
            case (state)
                DATA4: begin
                    oe  = 4'hF;
                    qdo = out_sr[7:4];
                end
                DATA1, ID, STAT: begin
                    oe  = 4'b0010;
                    qdo = {2'b00, out_sr[7], 1'b0};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master tasks, image memory model, expected-byte scoreboard.
module tb_spi_flash_responder;
    logic        clk = 1'b0;
    logic        rst, sclk, cs_n;
    logic [3:0]  qdi, qdo, oe;
    logic [23:0] mem_addr;
    logic        mem_rd, busy;
    logic [7:0]  mem_data;

    logic [7:0]  img [int];
    logic [7:0]  exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    spi_flash_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .qdi(qdi), .qdo(qdo), .oe(oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd) mem_data <= img.exists(int'(mem_addr)) ? img[int'(mem_addr)] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one sclk period: drive DQ0 in the low phase, sample outputs just before the rising edge
    task automatic cyc(input logic d0, output logic [3:0] q, output logic [3:0] o);
        qdi = {3'b000, d0};
        #60;
        q = qdo;
        o = oe;
        sclk = 1'b1;
        #60;
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        logic [3:0] q, o;
        for (int i = n - 1; i >= 0; i--) cyc(v[i], q, o);
    endtask

    task automatic start_cmd(input logic [7:0] c, input logic [23:0] a, input int nbits_addr, input int ndummy);
        logic [3:0] q, o, o_or;
        cs_n = 1'b0;
        #40;
        send_bits({16'h0, c}, 8);
        if (nbits_addr > 0) send_bits(a, nbits_addr);
        o_or = 4'h0;
        for (int i = 0; i < ndummy; i++) begin
            cyc(1'b0, q, o);
            o_or |= o;
        end
        if (ndummy > 0) check("dummy_oe", {28'h0, o_or}, 32'h0);
    endtask

    task automatic read1(input string tag, input int nbytes);
        logic [3:0] q, o, o_or, o_and;
        logic [7:0] b, e;
        for (int k = 0; k < nbytes; k++) begin
            o_or = 4'h0;
            o_and = 4'hF;
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                cyc(1'b0, q, o);
                b = {b[6:0], q[1]};
                o_or |= o;
                o_and &= o;
            end
            e = exp_q.pop_front();
            check(tag, {24'h0, b}, {24'h0, e});
            check({tag, "_oe"}, {24'h0, o_or, o_and}, 32'h22);
        end
    endtask

    task automatic read4(input string tag, input int nnib);
        logic [3:0] q, o;
        logic [7:0] e;
        for (int k = 0; k < nnib; k++) begin
            cyc(1'b0, q, o);
            e = exp_q.pop_front();
            check(tag, {28'h0, q}, {24'h0, e});
            check({tag, "_oe"}, {28'h0, o}, 32'hF);
        end
    endtask

    task automatic end_cs();
        cs_n = 1'b1;
        #100;
    endtask

    initial begin
        logic [3:0] q, o, o_or;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; qdi = 4'h0;
        img[32'h000100] = 8'hA5; img[32'h000101] = 8'h3C;
        img[32'hFFFFFF] = 8'h11; img[32'h000000] = 8'h22;
        img[32'h000010] = 8'h12; img[32'h000011] = 8'h34;
        #40;
        check("rst_qdo", {28'h0, qdo}, 32'h0);
        check("rst_oe", {28'h0, oe}, 32'h0);
        check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        #100;

        // plain read
        start_cmd(8'h03, 24'h000100, 24, 0);
        check("busy_active", {31'h0, busy}, 32'h1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        read1("rd03", 2);
        check("rd03_addr", {8'h0, mem_addr}, 32'h000102);
        end_cs();
        check("busy_idle", {31'h0, busy}, 32'h0);

        // fast read with address wrap
        start_cmd(8'h0B, 24'hFFFFFF, 24, 8);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        read1("rd0b", 2);
        end_cs();

        // quad output read
        start_cmd(8'h6B, 24'h000010, 24, 8);
        exp_q.push_back(8'h1); exp_q.push_back(8'h2); exp_q.push_back(8'h3); exp_q.push_back(8'h4);
        read4("rd6b", 4);
        end_cs();

        // JEDEC ID, status, unknown opcode
        start_cmd(8'h9F, 24'h0, 0, 0);
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h18);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        read1("jedec", 5);
        end_cs();
        start_cmd(8'h05, 24'h0, 0, 0);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
        read1("status", 3);
        end_cs();
        start_cmd(8'hAB, 24'h0, 0, 0);
        o_or = 4'h0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, q, o);
            o_or |= o;
        end
        check("ignore_oe", {28'h0, o_or}, 32'h0);
        end_cs();

        // abort mid-byte, then a clean read
        start_cmd(8'h03, 24'h000100, 24, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, q, o);
            check("abort_bits", {31'h0, q[1]}, {31'h0, (i % 2 == 0)});
        end
        cs_n = 1'b1;
        #28;
        check("abort_oe", {28'h0, oe}, 32'h0);
        #100;
        start_cmd(8'h03, 24'h000101, 24, 0);
        exp_q.push_back(8'h3C);
        read1("after_abort", 1);
        end_cs();

        // async reset mid quad read, then recovery
        start_cmd(8'h6B, 24'h000010, 24, 8);
        exp_q.push_back(8'h1);
        read4("pre_rst", 1);
        rst = 1'b1;
        #2;
        check("arst_qdo", {28'h0, qdo}, 32'h0);
        check("arst_oe", {28'h0, oe}, 32'h0);
        check("arst_mem_rd", {31'h0, mem_rd}, 32'h0);
        #38;
        rst = 1'b0;
        #40;
        o_or = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, q, o);
            o_or |= o;
        end
        check("post_rst_oe", {28'h0, o_or}, 32'h0);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        end_cs();
        start_cmd(8'h03, 24'h000100, 24, 0);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        read1("post_rst_rd", 2);
        end_cs();

        check("queue_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
